// File: rtl/router_pkg.sv
// Shared sizing constants for the router output FIFOs.
package router_pkg;

    localparam int unsigned ROUTER_DEPTH = 16;
    localparam int unsigned ROUTER_WIDTH = 8;
    localparam int unsigned ROUTER_PTR_W = $clog2(ROUTER_DEPTH) + 1;
    localparam int unsigned ROUTER_PKT_W = 7;

endpackage

// File: rtl/router_fifo_mem.sv
// FIFO storage: one write port, one registered read port with enable and clear.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = ROUTER_DEPTH,
    parameter int unsigned WIDTH = ROUTER_WIDTH,
    parameter int unsigned AW    = $clog2(ROUTER_DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH:0]   wr_data_i,
    input  logic             rd_en_i,
    input  logic             rd_clr_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH:0]   rd_data_o
);

    logic [WIDTH:0] mem_q [DEPTH];
    logic [WIDTH:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_clr_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/router_fifo.sv
// Per-channel router FIFO: pointer-based flags, header-driven packet counter, idle-zero output.
module router_fifo
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = ROUTER_DEPTH,
    parameter int unsigned WIDTH = ROUTER_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [ROUTER_PKT_W-1:0] pkt_cnt_q, pkt_eff;
    logic                    rd_done_q;
    logic [WIDTH:0]          rd_word;
    logic [ROUTER_PKT_W-1:0] hdr_len;
    logic                    flush, wr_acc, rd_acc, rd_clr;

    assign flush  = reset | soft_reset;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    assign wr_acc = write_enb & ~full & ~flush;
    assign rd_acc = read_enb & ~empty & ~flush;

    assign wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // The read port is registered, so the counter update for a read is folded in
    // one cycle later; pkt_eff is the count as of the end of the previous read.
    assign hdr_len = {1'b0, rd_word[7:2]} + 7'd1;

    always_comb begin
        pkt_eff = pkt_cnt_q;
        if (rd_done_q) begin
            if (rd_word[WIDTH]) begin
                pkt_eff = hdr_len;
            end else if (pkt_cnt_q != '0) begin
                pkt_eff = pkt_cnt_q - 7'd1;
            end
        end
    end

    assign rd_clr = flush | (~rd_acc & (pkt_eff == '0));

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            rd_done_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_eff;
            rd_done_q <= rd_acc;
        end
    end

    router_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk_i     (clock),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i ({lfd_state, data_in}),
        .rd_en_i   (rd_acc),
        .rd_clr_i  (rd_clr),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_word)
    );

    assign data_out = rd_word[WIDTH-1:0];

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus random traffic against a queue model.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset, soft_reset, write_enb, read_enb, lfd_state;
    logic [7:0] data_in, data_out;
    logic       full, empty;

    always #5 clock = ~clock;

    router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    logic [8:0]  mq [$];
    int unsigned m_pkt;
    logic [7:0]  m_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a packet is a header (length in bits [7:2]) followed by length+1 bytes.
    task automatic model(input logic r, input logic s, input logic w, input logic rd,
                         input logic l, input logic [7:0] d);
        logic [8:0] e;
        logic       racc, wacc;
        if (r || s) begin
            mq.delete();
            m_pkt  = 0;
            m_dout = 8'h00;
        end else begin
            racc = rd && (mq.size() != 0);
            wacc = w && (mq.size() != 16);
            if (racc) begin
                e      = mq.pop_front();
                m_dout = e[7:0];
                if (e[8]) m_pkt = int'(e[7:2]) + 1;
                else if (m_pkt != 0) m_pkt = m_pkt - 1;
            end else if (m_pkt == 0) begin
                m_dout = 8'h00;
            end
            if (wacc) mq.push_back({l, d});
        end
    endtask

    task automatic step(input logic r, input logic s, input logic w, input logic rd,
                        input logic l, input logic [7:0] d);
        reset      = r;
        soft_reset = s;
        write_enb  = w;
        read_enb   = rd;
        lfd_state  = l;
        data_in    = d;
        model(r, s, w, rd, l, d);
        @(posedge clock);
        #1;
        check("data_out", {24'h0, data_out}, {24'h0, m_dout});
        check("full",  {31'h0, full},  {31'h0, mq.size() == 16});
        check("empty", {31'h0, empty}, {31'h0, mq.size() == 0});
    endtask

    task automatic wr(input logic l, input logic [7:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b0, l, d);
    endtask

    task automatic rd1();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] pkt_bytes [5];
    logic [7:0] v;

    initial begin
        reset = 1'b0; soft_reset = 1'b0; write_enb = 1'b0;
        read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
        #1;

        // reset state
        do_reset();
        check("rst_empty", {31'h0, empty}, 32'd1);
        check("rst_full",  {31'h0, full},  32'd0);
        check("rst_dout",  {24'h0, data_out}, 32'h00);

        // header packet, read back-to-back, then idle clears the output
        pkt_bytes[0] = 8'h0C; pkt_bytes[1] = 8'hA1; pkt_bytes[2] = 8'hA2;
        pkt_bytes[3] = 8'hA3; pkt_bytes[4] = 8'h5E;
        for (int i = 0; i < 5; i++) wr(i == 0, pkt_bytes[i]);
        for (int i = 0; i < 5; i++) begin
            rd1();
            check("pkt_byte", {24'h0, data_out}, {24'h0, pkt_bytes[i]});
        end
        idle();
        check("pkt_idle_zero", {24'h0, data_out}, 32'h00);

        // fill to full, drop overflow, drain in order
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
        check("fill_full", {31'h0, full}, 32'd1);
        wr(1'b0, 8'hFF);
        check("ovf_full", {31'h0, full}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd1();
            check("drain_byte", {24'h0, data_out}, i);
        end
        check("drain_empty", {31'h0, empty}, 32'd1);

        // simultaneous read/write while full: read wins, write dropped
        for (int i = 0; i < 16; i++) wr(1'b0, 8'h40 + 8'(i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
        check("rw_full_dout", {24'h0, data_out}, 32'h40);
        check("rw_full_flag", {31'h0, full}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            rd1();
            check("rw_drain", {24'h0, data_out}, 32'h40 + i);
        end
        check("rw_empty", {31'h0, empty}, 32'd1);

        // soft reset beats a concurrent write
        for (int i = 0; i < 3; i++) wr(1'b0, 8'h10 + 8'(i));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        check("srst_empty", {31'h0, empty}, 32'd1);
        check("srst_dout",  {24'h0, data_out}, 32'h00);
        wr(1'b0, 8'h33);
        rd1();
        check("srst_after", {24'h0, data_out}, 32'h33);

        // pointer wrap
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) wr(1'b0, 8'h80 + 8'(k * 10 + i));
            for (int i = 0; i < 10; i++) begin
                rd1();
                check("wrap_byte", {24'h0, data_out}, 32'h80 + k * 10 + i);
            end
        end
        check("wrap_empty", {31'h0, empty}, 32'd1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            v = 8'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 7) == 0, v);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of storage entries (power of two).
REQ-002 Parameter: WIDTH, 8, data byte width.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 soft_reset  input  1  synchronous active-high per-port flush from the sync block (channel timeout).
REQ-006 write_enb  input  1  write request from the sync block for this channel.
REQ-007 read_enb  input  1  read request from the downstream destination.
REQ-008 lfd_state  input  1  FSM load-first-data flag; high marks data_in as a header byte.
REQ-009 data_in  input  WIDTH  byte from the router register stage.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 full  output  1  no free entry; feeds the FSM fifo_full path.
REQ-012 empty  output  1  no stored entry; feeds the FSM fifo_empty_N inputs.

Function
REQ-013 Storage SHALL be DEPTH entries of WIDTH+1 bits: {header flag, byte}.
REQ-014 Write and read pointers SHALL be log2(DEPTH)+1 bits; MSB is the wrap bit.
REQ-015 empty SHALL be 1 when the pointers are equal (all bits).
REQ-016 full SHALL be 1 when the pointer low bits are equal and the wrap bits differ.
REQ-017 full and empty SHALL be decoded combinationally from registered pointers only.
REQ-018 An accepted write (write_enb=1, full=0) SHALL store {lfd_state, data_in} at the write pointer and increment it by 1 at that edge.
REQ-019 A write with full=1 SHALL be dropped: no storage or pointer change.
REQ-020 An accepted read (read_enb=1, empty=0) SHALL load data_out with the stored byte and increment the read pointer; data_out is valid the cycle after read_enb is sampled (1-cycle latency).
REQ-021 A read with empty=1 SHALL leave pointers and data_out unchanged.
REQ-022 Simultaneous read and write SHALL be evaluated against the pre-edge full/empty: when full, only the read proceeds; when empty, only the write proceeds; otherwise both proceed and occupancy is unchanged.
REQ-023 Packet counter pkt_cnt (7 bits): an accepted read of a header-flagged entry SHALL load byte[7:2]+1 (payload length plus parity byte).
REQ-024 An accepted read of a non-header entry with pkt_cnt != 0 SHALL decrement pkt_cnt by 1; pkt_cnt SHALL never underflow.
REQ-025 When pkt_cnt = 0 and no read is accepted in a cycle, data_out SHALL be cleared to 0 at that edge (idle output; no tri-state).
REQ-026 Pointer arithmetic SHALL wrap modulo 2*DEPTH without special casing.

Reset
REQ-027 reset=1 SHALL, at the next rising edge, set both pointers and pkt_cnt to 0 and data_out to 0, giving empty=1, full=0.
REQ-028 soft_reset=1 SHALL have identical effect to reset; storage contents need not be cleared.
REQ-029 reset or soft_reset SHALL take priority over any write_enb/read_enb in the same cycle, including mid-packet.

Structure
REQ-030 DEPTH, WIDTH and the pointer width constant SHALL live in shared package router_pkg.
REQ-031 Storage SHALL be a sub-module router_fifo_mem (one write port, one synchronous read port); pointers, flags and pkt_cnt stay in router_fifo.

Verification
REQ-032 Assert reset 1 cycle -> empty=1, full=0, data_out=8'h00.
REQ-033 Write header 8'h0C with lfd_state=1, payload 8'hA1,8'hA2,8'hA3, parity 8'h5E; read 5 back-to-back -> data_out = 0C,A1,A2,A3,5E one cycle after each read_enb; next idle cycle data_out=8'h00.
REQ-034 Write 16 bytes 8'h00..8'h0F -> full=1 after 16th; 17th write (8'hFF) dropped; 16 reads return 00..0F in order; empty=1 after the last.
REQ-035 Full FIFO, read_enb=write_enb=1 for one cycle -> read returns oldest byte, write dropped, full=0 next cycle.
REQ-036 Three writes then soft_reset=1 with write_enb=1 -> empty=1 next cycle, data_out=0; a following write of 8'h33 then read returns 8'h33.
REQ-037 Write 10, read 10, write 10, read 10 -> order preserved across pointer wrap; empty=1 at end.
